// File: rtl/lns_sb_db_pipe.sv
// Three-stage valid/ready Gaussian-log unit: s_b(z)=log2(1+2^z) or d_b(z)=log2|1-2^z|
// via a piecewise two-shift approximation, with a sideband tag carried per sample.
module lns_sb_db_pipe #(
  parameter int W     = 11,
  parameter int TAG_W = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic signed [W-1:0] in_z,
  input  logic                in_sub,
  input  logic [TAG_W-1:0]    in_tag,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic [TAG_W-1:0]    out_tag,
  output logic                out_sing,
  output logic                out_zerr
);

  typedef struct packed {
    logic [3:0]  w1;
    logic [3:0]  w2;
    logic [10:0] a;
  } seg_t;

  // Segment parameters indexed by mode and the index chosen in stage 1.
  function automatic seg_t seg_lut(input logic sub, input logic [2:0] idx);
    seg_t s;
    s = '{w1: 4'd12, w2: 4'd12, a: 11'd1024};
    if (!sub) begin
      case (idx)
        3'd0:    s = '{w1: 4'd12, w2: 4'd1,  a: 11'd257};
        3'd1:    s = '{w1: 4'd2,  w2: 4'd3,  a: 11'd330};
        3'd2:    s = '{w1: 4'd12, w2: 4'd2,  a: 11'd421};
        3'd3:    s = '{w1: 4'd3,  w2: 4'd5,  a: 11'd519};
        3'd4:    s = '{w1: 4'd4,  w2: 4'd6,  a: 11'd664};
        3'd5:    s = '{w1: 4'd6,  w2: 4'd8,  a: 11'd1000};
        default: ;
      endcase
    end else begin
      case (idx)
        3'd0:    s = '{w1: 4'd0,  w2: 4'd0,  a: 11'd192};
        3'd1:    s = '{w1: 4'd1,  w2: 4'd4,  a: 11'd350};
        3'd2:    s = '{w1: 4'd3,  w2: 4'd5,  a: 11'd589};
        3'd3:    s = '{w1: 4'd6,  w2: 4'd12, a: 11'd1024};
        default: ;
      endcase
    end
    return s;
  endfunction

  // Handshake: each stage advances when empty or when the stage below advances.
  logic v1_q, v2_q, v3_q;
  logic adv1, adv2, adv3;

  assign adv3     = !v3_q || out_ready;
  assign adv2     = !v2_q || adv3;
  assign adv1     = !v1_q || adv2;
  assign in_ready = adv1;

  // Stage 1: clamp and segment select.
  int                  zc;
  logic signed [W-1:0] z_clamp;
  logic                zerr_c, sing_c;
  logic [2:0]          seg_c;

  // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
  always_comb begin
    zc     = int'(in_z);
    zerr_c = 1'b0;
    seg_c  = 3'd0;
    if (zc > 0) begin
      zc     = 0;
      zerr_c = 1'b1;
    end else if (zc < -1024) begin
      zc = -1024;
    end
    z_clamp = W'(zc);
    sing_c  = in_sub && (zc == 0);
    if (!in_sub) begin
      if      (zc > -47)  seg_c = 3'd0;
      else if (zc > -142) seg_c = 3'd1;
      else if (zc > -264) seg_c = 3'd2;
      else if (zc > -367) seg_c = 3'd3;
      else if (zc > -537) seg_c = 3'd4;
      else if (zc > -960) seg_c = 3'd5;
      else                seg_c = 3'd6;
    end else begin
      if      (zc > -128) seg_c = 3'd0;
      else if (zc > -256) seg_c = 3'd1;
      else if (zc > -512) seg_c = 3'd2;
      else if (zc > -960) seg_c = 3'd3;
      else                seg_c = 3'd4;
    end
  end

  logic signed [W-1:0] z1_q;
  logic [2:0]          seg1_q;
  logic                sub1_q, sing1_q, zerr1_q;
  logic [TAG_W-1:0]    tag1_q;

  // Stage 2: offset add in W+1 bits (a reaches 1024, beyond W-bit signed range at W=11).
  seg_t                seg2_c;
  logic signed [W:0]   t_d;

  always_comb begin
    seg2_c = seg_lut(sub1_q, seg1_q);
    t_d    = {z1_q[W-1], z1_q} + {{(W-10){1'b0}}, seg2_c.a};
  end

  logic signed [W:0]   t2_q;
  logic [3:0]          w1_2_q, w2_2_q;
  logic                sub2_q, sing2_q, zerr2_q;
  logic [TAG_W-1:0]    tag2_q;

  // Stage 3: two arithmetic shifts, optional negate, singularity override.
  logic signed [W:0]   r_c, neg_r_c;
  logic signed [W-1:0] res_d;

  always_comb begin
    r_c     = (t2_q >>> w1_2_q) + (t2_q >>> w2_2_q);
    neg_r_c = -r_c;
    if (sing2_q)     res_d = {1'b1, {(W-1){1'b0}}};
    else if (sub2_q) res_d = neg_r_c[W-1:0];
    else             res_d = r_c[W-1:0];
  end

  // NOTE: internal datapath registers carry no reset; only valid bits and visible outputs need one.
  always_ff @(posedge clk) begin
    if (adv1 && in_valid) begin
      z1_q    <= z_clamp;
      seg1_q  <= seg_c;
      sub1_q  <= in_sub;
      sing1_q <= sing_c;
      zerr1_q <= zerr_c;
      tag1_q  <= in_tag;
    end
    if (adv2 && v1_q) begin
      t2_q    <= t_d;
      w1_2_q  <= seg2_c.w1;
      w2_2_q  <= seg2_c.w2;
      sub2_q  <= sub1_q;
      sing2_q <= sing1_q;
      zerr2_q <= zerr1_q;
      tag2_q  <= tag1_q;
    end
  end

  logic signed [W-1:0] out_data_q;
  logic [TAG_W-1:0]    out_tag_q;
  logic                out_sing_q, out_zerr_q;

  // NOTE: sequential state uses non-blocking assignments so all stages update from pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v1_q       <= 1'b0;
      v2_q       <= 1'b0;
      v3_q       <= 1'b0;
      out_data_q <= '0;
      out_tag_q  <= '0;
      out_sing_q <= 1'b0;
      out_zerr_q <= 1'b0;
    end else begin
      if (adv1) v1_q <= in_valid;
      if (adv2) v2_q <= v1_q;
      if (adv3) begin
        v3_q <= v2_q;
        if (v2_q) begin
          out_data_q <= res_d;
          out_tag_q  <= tag2_q;
          out_sing_q <= sing2_q;
          out_zerr_q <= zerr2_q;
        end
      end
    end
  end

  assign out_valid = v3_q;
  assign out_data  = out_data_q;
  assign out_tag   = out_tag_q;
  assign out_sing  = out_sing_q;
  assign out_zerr  = out_zerr_q;

endmodule
